// File: rtl/rr_demux_dist.sv
// rtl/rr_demux_dist.sv - one-to-four demux with per-channel one-entry buffers, explicit or round-robin select
// Optional feature: define DEMUX_XFER_CNT_EN to add an 8-bit wrapping transfer counter on port cnt.
module rr_demux_dist #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] a,
  input  logic         a_v,
  output logic         a_r,
  input  logic         mode,
  input  logic         s1,
  input  logic         s2,
  output logic [W-1:0] o1,
  output logic [W-1:0] o2,
  output logic [W-1:0] o3,
  output logic [W-1:0] o4,
  output logic         v1,
  output logic         v2,
  output logic         v3,
  output logic         v4,
  input  logic         r1,
  input  logic         r2,
  input  logic         r3,
  input  logic         r4,
`ifdef DEMUX_XFER_CNT_EN
  output logic [7:0]   cnt,
`endif
  output logic [1:0]   ptr
);

  logic [1:0]   tgt;
  logic [3:0]   full;
  logic [3:0]   rdy;
  logic [3:0]   load;
  logic [3:0]   drain;
  logic         xfer;
  logic [W-1:0] buf_q [4];

  assign rdy   = {r4, r3, r2, r1};
  assign drain = full & rdy;

  // Target channel: explicit select or the round-robin pointer, same cycle.
  always_comb begin
    tgt = mode ? ptr : {s1, s2};
  end

  // Ready looks only at the target buffer; a draining full buffer still accepts.
  assign a_r  = !full[tgt] | rdy[tgt];
  assign xfer = a_v & a_r;

  // One-hot load strobe for the channel receiving this cycle's word.
  always_comb begin
    load = '0;
    if (xfer) begin
      load[tgt] = 1'b1;
    end
  end

  // Per-channel buffers: a reload wins over a drain so the slot stays valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= '0;
      for (int i = 0; i < 4; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (load[i]) begin
          buf_q[i] <= a;
          full[i]  <= 1'b1;
        end else if (drain[i]) begin
          full[i]  <= 1'b0;
        end
      end
    end
  end

  // Pointer advances only on transfers made in round-robin mode; otherwise held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 2'd0;
    end else if (mode && xfer) begin
      ptr <= ptr + 2'd1;
    end
  end

`ifdef DEMUX_XFER_CNT_EN
  // Free-running count of accepted words, wrapping at 256.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 8'd0;
    end else if (xfer) begin
      cnt <= cnt + 8'd1;
    end
  end
`endif

  assign o1 = buf_q[0];
  assign o2 = buf_q[1];
  assign o3 = buf_q[2];
  assign o4 = buf_q[3];
  assign v1 = full[0];
  assign v2 = full[1];
  assign v3 = full[2];
  assign v4 = full[3];

endmodule

// File: tb/tb_rr_demux_dist.sv
// tb/tb_rr_demux_dist.sv - directed bench with behavioural buffer model for rr_demux_dist
module tb_rr_demux_dist;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] a = '0;
  logic         a_v = 1'b0;
  logic         a_r;
  logic         mode = 1'b0;
  logic         s1 = 1'b0;
  logic         s2 = 1'b0;
  logic [W-1:0] o1, o2, o3, o4;
  logic         v1, v2, v3, v4;
  logic [3:0]   rr = 4'h0;
  logic [1:0]   ptr;
`ifdef DEMUX_XFER_CNT_EN
  logic [7:0]   cnt;
`endif

  int nvec = 0;
  int nerr = 0;

  // Model state: what each channel slot holds, pointer, and transfer count.
  logic         mv [4];
  logic [W-1:0] mo [4];
  int           mptr;
  int           mcnt;

  rr_demux_dist #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .a_v(a_v), .a_r(a_r),
    .mode(mode), .s1(s1), .s2(s2),
    .o1(o1), .o2(o2), .o3(o3), .o4(o4),
    .v1(v1), .v2(v2), .v3(v3), .v4(v4),
    .r1(rr[0]), .r2(rr[1]), .r3(rr[2]), .r4(rr[3]),
`ifdef DEMUX_XFER_CNT_EN
    .cnt(cnt),
`endif
    .ptr(ptr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int target();
    return mode ? mptr : int'({s1, s2});
  endfunction

  function automatic logic model_ready();
    int t;
    t = target();
    return !mv[t] || rr[t];
  endfunction

  // Model: a word goes to the selected slot; any ready consumer empties its slot.
  always @(posedge clk or negedge rst_n) begin : model
    int t;
    logic take;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        mv[i] <= 1'b0;
        mo[i] <= '0;
      end
      mptr <= 0;
      mcnt <= 0;
    end else begin
      t = target();
      take = a_v && model_ready();
      for (int i = 0; i < 4; i++) begin
        if (take && i == t) begin
          mv[i] <= 1'b1;
          mo[i] <= a;
        end else if (mv[i] && rr[i]) begin
          mv[i] <= 1'b0;
        end
      end
      if (take) begin
        mcnt <= (mcnt + 1) % 256;
        if (mode) mptr <= (mptr + 1) % 4;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("a_r", 32'(a_r), 32'(model_ready()));
    chk("ptr", 32'(ptr), 32'(mptr));
    chk("v", 32'({v4, v3, v2, v1}), 32'({mv[3], mv[2], mv[1], mv[0]}));
    chk("o1", 32'(o1), 32'(mo[0]));
    chk("o2", 32'(o2), 32'(mo[1]));
    chk("o3", 32'(o3), 32'(mo[2]));
    chk("o4", 32'(o4), 32'(mo[3]));
`ifdef DEMUX_XFER_CNT_EN
    chk("cnt", 32'(cnt), 32'(mcnt));
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] words [5];

  initial begin
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
    words[3] = 8'h44; words[4] = 8'h55;

    step();
    step();
    chk("rst_v", 32'({v4, v3, v2, v1}), 32'h0);
    chk("rst_ptr", 32'(ptr), 32'h0);
    rst_n = 1'b1;

    // Round-robin over all four channels and wrap to ch1.
    mode = 1'b1; rr = 4'hF; a_v = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a = words[i];
      #1;
      chk("rr_ptr_pre", 32'(ptr), 32'(i % 4));
      step();
      chk("rr_ptr_post", 32'(ptr), 32'((i + 1) % 4));
      case (i)
        0: chk("rr_o1", 32'(o1), 32'h11);
        1: chk("rr_o2", 32'(o2), 32'h22);
        2: chk("rr_o3", 32'(o3), 32'h33);
        3: chk("rr_o4", 32'(o4), 32'h44);
        default: chk("rr_o1_wrap", 32'(o1), 32'h55);
      endcase
    end
    a_v = 1'b0;
    step();

    // Explicit ch3 with a stalled consumer, then same-cycle drain and reload.
    mode = 1'b0; s1 = 1'b1; s2 = 1'b0; rr = 4'b1011;
    a = 8'hA0; a_v = 1'b1;
    #1;
    chk("ch3_ar_empty", 32'(a_r), 32'h1);
    step();
    chk("ch3_v", 32'(v3), 32'h1);
    chk("ch3_o", 32'(o3), 32'hA0);
    a = 8'hA1;
    #1;
    chk("ch3_ar_full", 32'(a_r), 32'h0);
    step();
    chk("ch3_hold", 32'(o3), 32'hA0);
    chk("ptr_hold_m0", 32'(ptr), 32'h1);
    rr = 4'hF;
    #1;
    chk("ch3_ar_drain", 32'(a_r), 32'h1);
    step();
    chk("ch3_o_new", 32'(o3), 32'hA1);
    chk("ch3_v_kept", 32'(v3), 32'h1);
    a_v = 1'b0;
    step();
    chk("ch3_v_clear", 32'(v3), 32'h0);

    // Blocked on full ch2, retarget to ch1 in the same cycle.
    s1 = 1'b0; s2 = 1'b1; rr = 4'b1101;
    a = 8'hB0; a_v = 1'b1;
    step();
    a = 8'hB1;
    #1;
    chk("ch2_ar_block", 32'(a_r), 32'h0);
    s2 = 1'b0;
    #1;
    chk("ch1_ar_switch", 32'(a_r), 32'h1);
    step();
    chk("ch1_o_land", 32'(o1), 32'hB1);
    chk("ch2_o_kept", 32'(o2), 32'hB0);
    a_v = 1'b0; rr = 4'hF;
    step();

    // Fill all four buffers, then reset mid-cycle.
    mode = 1'b1; rr = 4'h0; a_v = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = 8'hD0 + 8'(i);
      step();
    end
    a_v = 1'b0;
    chk("fill_all_v", 32'({v4, v3, v2, v1}), 32'hF);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_v", 32'({v4, v3, v2, v1}), 32'h0);
    chk("arst_o", 32'({o4, o3, o2, o1}), 32'h0);
    chk("arst_ptr", 32'(ptr), 32'h0);
    step();
    rst_n = 1'b1;
    rr = 4'hF; a = 8'hC0; a_v = 1'b1;
    step();
    chk("post_rst_v", 32'({v4, v3, v2, v1}), 32'h1);
    chk("post_rst_o1", 32'(o1), 32'hC0);

    // Reset, then 257 back-to-back round-robin transfers.
    a_v = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    a_v = 1'b1;
    for (int i = 0; i < 257; i++) begin
      a = 8'(i);
      step();
    end
    a_v = 1'b0;
    chk("long_ptr", 32'(ptr), 32'h1);
    chk("long_o1", 32'(o1), 32'h00);
`ifdef DEMUX_XFER_CNT_EN
    chk("cnt_257", 32'(cnt), 32'h1);
`endif
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/rr_demux_dist.md
RR_DEMUX_DIST -- requirements
Module: rr_demux_dist

Interface
REQ-001 Parameter W, default 8: data width of the input and of each output channel.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 a  input  W  input data word.
REQ-005 a_v  input  1  input valid.
REQ-006 a_r  output  1  input ready; a transfer SHALL occur on a cycle with a_v=1 and a_r=1.
REQ-007 mode  input  1  select source: 0 = explicit select on s1,s2; 1 = internal round-robin pointer.
REQ-008 s1, s2  input  1 each  explicit channel select, s1 as MSB: 00 = ch1, 01 = ch2, 10 = ch3, 11 = ch4.
REQ-009 o1..o4  output  W each  registered channel data.
REQ-010 v1..v4  output  1 each  channel valid.
REQ-011 r1..r4  input  1 each  channel ready from the consumer.
REQ-012 ptr  output  2  current round-robin pointer.

Function
REQ-013 Target channel t SHALL be {s1,s2} when mode=0 and ptr when mode=1, decoded combinationally in the same cycle.
REQ-014 Each channel SHALL hold a one-entry buffer (oN, vN).
REQ-015 a_r SHALL be (!vt | rt) for target t, so a full channel that is draining accepts in the same cycle.
REQ-016 On a transfer, oT SHALL load a and vT SHALL be 1 on the next edge (latency 1 cycle).
REQ-017 A channel drains when vN=1 and rN=1; vN SHALL clear on the next edge unless the same channel is reloaded in that cycle, in which case vN stays 1 with the new data.
REQ-018 While vN=1 and rN=0, oN SHALL hold stable and a_r SHALL be 0 when N is the target.
REQ-019 Non-target channels SHALL drain independently and SHALL never be written.
REQ-020 In mode=1, ptr SHALL increment by 1 after each transfer and wrap from 3 to 0; without a transfer ptr SHALL hold.
REQ-021 In mode=0, ptr SHALL hold its value; a switch back to mode=1 resumes from the held value.
REQ-022 A change of mode, s1 or s2 SHALL take effect in the same cycle with no lost or duplicated word.
REQ-023 a_r SHALL not depend on a_v.

Reset
REQ-024 On rst_n=0, v1..v4, o1..o4 and ptr SHALL go to 0 immediately, without waiting for a clock edge.
REQ-025 Reset asserted during operation SHALL discard all buffered words.
REQ-026 The first transfer after rst_n deasserts SHALL go to ch1 in mode=1.

Configuration
REQ-027 Macro DEMUX_XFER_CNT_EN defined: the block SHALL add output port cnt (output, 8 bits), which counts transfers, wraps from 255 to 0 and resets to 0.
REQ-028 Macro DEMUX_XFER_CNT_EN not defined: the block SHALL have no cnt port and no counter logic, and all other behaviour SHALL be identical.

Verification
REQ-029 The bench SHALL cover: mode=1, r1..r4=1, a_v=1 with words 0x11, 0x22, 0x33, 0x44, 0x55 -> o1=0x11, o2=0x22, o3=0x33, o4=0x44, then o1=0x55, each 1 cycle after its transfer, with ptr sequence 0,1,2,3,0,1.
REQ-030 The bench SHALL cover: mode=0, s1s2=10, r3=0, two words 0xA0 and 0xA1 -> first accepted with v3=1 and o3=0xA0, then a_r=0 and o3 held; on r3=1, 0xA1 is accepted in the same cycle and o3=0xA1 on the next edge with v3 still 1.
REQ-031 The bench SHALL cover: ch2 full with r2=0 and target ch2 -> a_r=0; switch to s1s2=00 -> a_r=1 that same cycle and the word lands on o1.
REQ-032 The bench SHALL cover: rst_n pulsed low mid-stream with v1..v4 all 1 -> all vN=0, oN=0 and ptr=0 before the next clock edge, and the next word goes to ch1.
REQ-033 The bench SHALL cover: with DEMUX_XFER_CNT_EN defined, 257 transfers -> cnt=1; with the macro undefined, the build succeeds without a cnt port.
